// File: rtl/rsp_packer_pkg.sv
// Shared widths for the response path: the packer word width must equal
// the rsp FIFO width, so both sides take their defaults from here.
package rsp_packer_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 128;
    localparam int unsigned DEF_BEAT_WIDTH = 32;
    localparam int unsigned DEF_BEATS      = DEF_DATA_WIDTH / DEF_BEAT_WIDTH;
    localparam int unsigned DEF_CNT_W      = $clog2(DEF_BEATS);
    localparam int unsigned RSP_FIFO_WIDTH = DEF_DATA_WIDTH;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HELD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/rsp_packer_if.sv
// Beat input and FIFO push handshakes of the response packer.
interface rsp_packer_if #(
    parameter int unsigned DATA_WIDTH = rsp_packer_pkg::DEF_DATA_WIDTH,
    parameter int unsigned BEAT_WIDTH = rsp_packer_pkg::DEF_BEAT_WIDTH
) ();

    logic                  io_beat_valid;
    logic                  io_beat_ready;
    logic [BEAT_WIDTH-1:0] io_beat_data;
    logic                  io_beat_last;
    logic                  io_push_valid;
    logic                  io_push_ready;
    logic [DATA_WIDTH-1:0] io_push_rsp_data;

    modport master (
        output io_beat_valid, io_beat_data, io_beat_last, io_push_ready,
        input  io_beat_ready, io_push_valid, io_push_rsp_data
    );

    modport slave (
        input  io_beat_valid, io_beat_data, io_beat_last, io_push_ready,
        output io_beat_ready, io_push_valid, io_push_rsp_data
    );

endinterface

// File: rtl/rsp_packer.sv
// Packs controller read beats (LSB first) into response words and feeds the
// rsp FIFO push port through a one-entry output register.
module rsp_packer
    import rsp_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BEAT_WIDTH = DEF_BEAT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    rsp_packer_if.slave  bus,
    input  logic         err_clr,
    output logic         overflow_err,
    output logic         short_err
);

    localparam int unsigned BEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (((DATA_WIDTH % BEAT_WIDTH) != 0) || (BEATS < 2)) begin : g_param_check
        $error("rsp_packer: DATA_WIDTH must be a multiple of BEAT_WIDTH with at least 2 beats");
    end

    pack_state_e           state_r, state_n;
    logic [CNT_W-1:0]      cnt_r, cnt_n;
    logic [DATA_WIDTH-1:0] asm_r, asm_n;
    logic                  out_valid_r, out_valid_n;
    logic [DATA_WIDTH-1:0] out_data_r, out_data_n;
    logic                  ovf_r, ovf_n;
    logic                  short_r, short_n;

    logic                  accept_s;
    logic                  at_final_s;
    logic                  complete_s;
    logic                  out_free_s;
    logic                  overflow_s;
    logic                  early_last_s;
    logic [DATA_WIDTH-1:0] filled_s;

    assign accept_s     = bus.io_beat_valid && (state_r == ST_FILL);
    assign at_final_s   = (cnt_r == CNT_W'(BEATS - 1));
    assign complete_s   = accept_s && (at_final_s || bus.io_beat_last);
    assign early_last_s = accept_s && bus.io_beat_last && !at_final_s;
    assign overflow_s   = bus.io_beat_valid && (state_r == ST_HELD);
    assign out_free_s   = !out_valid_r || bus.io_push_ready;

    assign bus.io_beat_ready    = (state_r == ST_FILL);
    assign bus.io_push_valid    = out_valid_r;
    assign bus.io_push_rsp_data = out_data_r;
    assign overflow_err         = ovf_r;
    assign short_err            = short_r;

    // Next-state: beat assembly, hand-off to the output register, sticky errors
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        asm_n       = asm_r;
        out_valid_n = out_valid_r && !bus.io_push_ready;
        out_data_n  = out_data_r;
        ovf_n       = ovf_r;
        short_n     = short_r;

        for (int k = 0; k < BEATS; k++) begin
            filled_s[k*BEAT_WIDTH +: BEAT_WIDTH] = (cnt_r == CNT_W'(k)) ?
                bus.io_beat_data : asm_r[k*BEAT_WIDTH +: BEAT_WIDTH];
        end

        case (state_r)
            ST_FILL: begin
                if (complete_s) begin
                    cnt_n = {CNT_W{1'b0}};
                    if (out_free_s) begin
                        out_valid_n = 1'b1;
                        out_data_n  = filled_s;
                        asm_n       = {DATA_WIDTH{1'b0}};
                    end else begin
                        // Word parks in the assembly register until the output frees up
                        asm_n   = filled_s;
                        state_n = ST_HELD;
                    end
                end else if (accept_s) begin
                    asm_n = filled_s;
                    cnt_n = cnt_r + CNT_W'(1);
                end else begin
                    asm_n = asm_r;
                end
            end
            ST_HELD: begin
                if (out_free_s) begin
                    out_valid_n = 1'b1;
                    out_data_n  = asm_r;
                    asm_n       = {DATA_WIDTH{1'b0}};
                    state_n     = ST_FILL;
                end else begin
                    state_n = ST_HELD;
                end
            end
            default: begin
                state_n = ST_FILL;
                cnt_n   = {CNT_W{1'b0}};
                asm_n   = {DATA_WIDTH{1'b0}};
            end
        endcase

        if (overflow_s) begin
            ovf_n = 1'b1;
        end else if (err_clr) begin
            ovf_n = 1'b0;
        end else begin
            ovf_n = ovf_r;
        end

        if (early_last_s) begin
            short_n = 1'b1;
        end else if (err_clr) begin
            short_n = 1'b0;
        end else begin
            short_n = short_r;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_FILL;
            cnt_r       <= {CNT_W{1'b0}};
            asm_r       <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            ovf_r       <= 1'b0;
            short_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            asm_r       <= asm_n;
            out_valid_r <= out_valid_n;
            out_data_r  <= out_data_n;
            ovf_r       <= ovf_n;
            short_r     <= short_n;
        end
    end

endmodule

// File: tb/tb_rsp_packer.sv
// Self-checking bench for rsp_packer: directed vector table, a reset
// sequence, and a randomized run against a word-level reference model.
module tb_rsp_packer;

    logic clk;
    logic rst;
    logic err_clr;
    logic overflow_err;
    logic short_err;

    int checks;
    int errors;

    rsp_packer_if bus ();

    rsp_packer dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .err_clr      (err_clr),
        .overflow_err (overflow_err),
        .short_err    (short_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         bv;
        logic [31:0]  bd;
        logic         bl;
        logic         pr;
        logic         ec;
        logic         e_pv;
        logic [127:0] e_pd;
        logic         e_br;
        logic         e_ovf;
        logic         e_sh;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic bv, logic [31:0] bd, logic bl, logic pr,
                                logic ec, logic epv, logic [127:0] epd, logic ebr,
                                logic eovf, logic esh);
        vec_t v;
        v.rst = r; v.bv = bv; v.bd = bd; v.bl = bl; v.pr = pr; v.ec = ec;
        v.e_pv = epv; v.e_pd = epd; v.e_br = ebr; v.e_ovf = eovf; v.e_sh = esh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic bv, input logic [31:0] bd,
                         input logic bl, input logic pr, input logic ec);
        rst               = r;
        bus.io_beat_valid = bv;
        bus.io_beat_data  = bd;
        bus.io_beat_last  = bl;
        bus.io_push_ready = pr;
        err_clr           = ec;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] W1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] WS = {64'h0, 32'hBBBBBBBB, 32'hAAAAAAAA};
    localparam logic [127:0] WA = {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1};
    localparam logic [127:0] WB = {32'hB4B4B4B4, 32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1};
    localparam logic [127:0] WC = {32'hC4C4C4C4, 32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1};
    localparam logic [127:0] WR = {32'h55555554, 32'h55555553, 32'h55555552, 32'h55555551};
    localparam logic [127:0] Z  = 128'h0;

    initial begin
        logic [31:0]  bq[$];
        logic         lq[$];
        logic [127:0] exp_q[$];
        logic [127:0] word;
        logic [127:0] exp_w;
        logic [127:0] prev_data;
        logic         prev_stall;
        logic         exp_short;
        int           k;
        int           n_words;
        int           bi;
        int           got;
        int           cyc;

        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // rst | bv bd bl | pr ec || pv pd br ovf sh
        tbl.push_back(mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h33333333, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h44444444, 1'b0, 1'b1, 1'b0, 1'b1, W1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        // early last -> zero-filled upper beats, short_err, then clear
        tbl.push_back(mk(1'b0, 1'b1, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hBBBBBBBB, 1'b1, 1'b1, 1'b0, 1'b1, WS, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        // FIFO stalled: A in output, B held, overflow beats dropped
        tbl.push_back(mk(1'b0, 1'b1, 32'hA1A1A1A1, 1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hA2A2A2A2, 1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hA3A3A3A3, 1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hA4A4A4A4, 1'b0, 1'b0, 1'b0, 1'b1, WA, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hB1B1B1B1, 1'b0, 1'b0, 1'b0, 1'b1, WA, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hB2B2B2B2, 1'b0, 1'b0, 1'b0, 1'b1, WA, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hB3B3B3B3, 1'b0, 1'b0, 1'b0, 1'b1, WA, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hB4B4B4B4, 1'b0, 1'b0, 1'b0, 1'b1, WA, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b0, 1'b1, WA, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hDEAD0002, 1'b0, 1'b0, 1'b1, 1'b1, WA, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, WB, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hC1C1C1C1, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hC2C2C2C2, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hC3C3C3C3, 1'b0, 1'b1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'hC4C4C4C4, 1'b0, 1'b1, 1'b0, 1'b1, WC, 1'b1, 1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].bv, tbl[i].bd, tbl[i].bl, tbl[i].pr, tbl[i].ec);
            step();
            chk($sformatf("row%0d push_valid", i), {127'h0, bus.io_push_valid}, {127'h0, tbl[i].e_pv});
            if (tbl[i].e_pv) begin
                chk($sformatf("row%0d push_data", i), bus.io_push_rsp_data, tbl[i].e_pd);
            end
            chk($sformatf("row%0d beat_ready", i), {127'h0, bus.io_beat_ready}, {127'h0, tbl[i].e_br});
            chk($sformatf("row%0d overflow_err", i), {127'h0, overflow_err}, {127'h0, tbl[i].e_ovf});
            chk($sformatf("row%0d short_err", i), {127'h0, short_err}, {127'h0, tbl[i].e_sh});
        end

        // Reset in mid-response discards the partial word and the sticky flags
        drive(1'b0, 1'b1, 32'h77777777, 1'b1, 1'b1, 1'b0); step();
        chk("pre-reset short_err", {127'h0, short_err}, 128'h1);
        drive(1'b0, 1'b1, 32'hEEEEEEE1, 1'b0, 1'b1, 1'b0); step();
        drive(1'b0, 1'b1, 32'hEEEEEEE2, 1'b0, 1'b1, 1'b0); step();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); step();
        chk("reset push_valid", {127'h0, bus.io_push_valid}, 128'h0);
        chk("reset short_err", {127'h0, short_err}, 128'h0);
        chk("reset overflow_err", {127'h0, overflow_err}, 128'h0);
        chk("reset beat_ready", {127'h0, bus.io_beat_ready}, 128'h1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, WR[i*32 +: 32], 1'b0, 1'b1, 1'b0); step();
        end
        chk("post-reset push_valid", {127'h0, bus.io_push_valid}, 128'h1);
        chk("post-reset push_data", bus.io_push_rsp_data, WR);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0); step();

        // Reference model: split the beat stream into words by count or last
        k = 0; word = '0; n_words = 0; exp_short = 1'b0;
        while (n_words < 64) begin
            bq.push_back($urandom);
            lq.push_back($urandom_range(0, 7) == 0);
            word = word | ({96'h0, bq[bq.size()-1]} << (32 * k));
            if (k == 3 || lq[lq.size()-1]) begin
                if (k != 3) exp_short = 1'b1;
                exp_q.push_back(word);
                word = '0; k = 0; n_words++;
            end else begin
                k++;
            end
        end

        bi = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        while (got < n_words && cyc < 4000) begin
            bus.io_push_ready = ($urandom_range(0, 1) == 1);
            if (bi < bq.size() && bus.io_beat_ready) begin
                bus.io_beat_valid = 1'b1;
                bus.io_beat_data  = bq[bi];
                bus.io_beat_last  = lq[bi];
                bi++;
            end else begin
                bus.io_beat_valid = 1'b0;
                bus.io_beat_data  = 32'h0;
                bus.io_beat_last  = 1'b0;
            end
            if (prev_stall) begin
                chk("stall valid held", {127'h0, bus.io_push_valid}, 128'h1);
                chk("stall data held", bus.io_push_rsp_data, prev_data);
            end
            if (bus.io_push_valid && bus.io_push_ready) begin
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    chk($sformatf("rand word%0d", got), bus.io_push_rsp_data, exp_w);
                end else begin
                    chk("rand extra word", 128'h1, 128'h0);
                end
                got++;
            end
            prev_stall = bus.io_push_valid && !bus.io_push_ready;
            prev_data  = bus.io_push_rsp_data;
            step();
            cyc++;
        end
        chk("rand word count", 128'(got), 128'(n_words));
        chk("rand overflow_err", {127'h0, overflow_err}, 128'h0);
        chk("rand short_err", {127'h0, short_err}, {127'h0, exp_short});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
